// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions for the line client: tag layout,
// beat count and the client state encoding.
package sysbus_pkg;

   localparam logic SYSBUS_READ  = 1'b0;
   localparam logic SYSBUS_WRITE = 1'b1;

   localparam int BEATS       = 8;
   localparam int BEAT_IDX_W  = 3;
   localparam int TAG_DIR_BIT = 12;
   localparam int TAG_ID_MSB  = 11;
   localparam int TAG_ID_LSB  = 0;
   localparam int LINE_OFS_W  = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WBEAT,
      ST_RBEAT,
      ST_FIN
   } state_e;

   function automatic logic [BEATS-1:0] beat_onehot(
      input logic [BEAT_IDX_W-1:0] idx
   );
      return BEATS'(1) << idx;
   endfunction

endpackage

// File: rtl/line_assembler.sv
// Read-line assembly: beat storage, per-beat captured mask and
// completion detect that already includes the beat being written.
module line_assembler
   import sysbus_pkg::*;
#(
   parameter int BEAT_W = 64,
   parameter int LINE_W = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  wr_i,
   input  logic [BEAT_IDX_W-1:0] idx_i,
   input  logic [BEAT_W-1:0]     data_i,
   output logic [LINE_W-1:0]     rdata_o,
   output logic                  seen_o,
   output logic                  full_o
);

   logic [BEATS-1:0]  mask_q, mask_d;
   logic [LINE_W-1:0] rdata_q;

   always_comb begin
      mask_d = mask_q;
      if (clr_i) begin
         mask_d = '0;
      end else if (wr_i) begin
         mask_d = mask_q | beat_onehot(idx_i);
      end
   end

   assign seen_o  = mask_q[idx_i];
   // Looks ahead so the FSM can leave on the cycle of the last capture
   assign full_o  = &mask_d;
   assign rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         mask_q <= mask_d;
         if (wr_i) begin
            rdata_q[int'(idx_i)*BEAT_W +: BEAT_W] <= data_i;
         end
      end
   end

endmodule

// File: rtl/mem_line_client.sv
// Single-line bus client: issues an address beat, then either streams
// eight write beats or collects eight read beats in any order.
module mem_line_client
   import sysbus_pkg::*;
#(
   parameter int                  BUS_DATA_WIDTH = 64,
   parameter int                  BUS_TAG_WIDTH  = 13,
   parameter int                  LINE_WIDTH     = 512,
   parameter logic [TAG_ID_MSB:0] TAG_ID         = 12'h000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      we,
   input  logic [BUS_DATA_WIDTH-1:0] addr,
   input  logic [LINE_WIDTH-1:0]     wdata,
   output logic                      idle,
   output logic                      done,
   output logic [LINE_WIDTH-1:0]     rdata,
   output logic                      err,
   output logic                      reqcyc,
   input  logic                      reqack,
   output logic [BUS_DATA_WIDTH-1:0] req,
   output logic [BUS_TAG_WIDTH-1:0]  reqtag,
   input  logic                      respcyc,
   output logic                      respack,
   input  logic [BUS_DATA_WIDTH-1:0] resp,
   input  logic [8:0]                ptr
);

   localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK =
      ~BUS_DATA_WIDTH'((1 << LINE_OFS_W) - 1);

   state_e                    state_q, state_d;
   logic                      we_q, we_d;
   logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0]     wdata_q, wdata_d;
   logic [BEAT_IDX_W-1:0]     cnt_q, cnt_d;
   logic                      err_q, err_d;

   logic                      clr;
   logic                      cap;
   logic                      seen;
   logic                      full;
   logic                      ptr_ok;
   logic [BUS_TAG_WIDTH-1:0]  tag_w;

   assign ptr_ok = (ptr[8:BEAT_IDX_W] == '0);
   assign err    = err_q;

   always_comb begin
      tag_w = '0;
      tag_w[TAG_DIR_BIT] = we_q;
      tag_w[TAG_ID_MSB:TAG_ID_LSB] = TAG_ID;
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      clr     = 1'b0;
      cap     = 1'b0;
      idle    = 1'b0;
      done    = 1'b0;
      reqcyc  = 1'b0;
      req     = '0;
      reqtag  = '0;
      respack = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            idle = 1'b1;
            if (start) begin
               we_d    = we;
               addr_d  = addr & ALIGN_MASK;
               wdata_d = wdata;
               cnt_d   = '0;
               err_d   = 1'b0;
               clr     = 1'b1;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            reqcyc = 1'b1;
            req    = addr_q;
            reqtag = tag_w;
            if (reqack) begin
               state_d = (we_q == SYSBUS_WRITE) ? ST_WBEAT : ST_RBEAT;
            end
         end
         ST_WBEAT: begin
            reqcyc = 1'b1;
            req    = wdata_q[int'(cnt_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            reqtag = tag_w;
            if (reqack) begin
               if (cnt_q == BEAT_IDX_W'(BEATS - 1)) begin
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RBEAT: begin
            if (respcyc) begin
               if (!ptr_ok) begin
                  respack = 1'b1;
                  err_d   = 1'b1;
               end else if (!seen) begin
                  respack = 1'b1;
                  cap     = 1'b1;
               end
            end
            if (full) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         we_q    <= SYSBUS_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   line_assembler #(
      .BEAT_W (BUS_DATA_WIDTH),
      .LINE_W (LINE_WIDTH)
   ) u_asm (
      .clk     (clk),
      .rst_n   (reset),
      .clr_i   (clr),
      .wr_i    (cap),
      .idx_i   (ptr[BEAT_IDX_W-1:0]),
      .data_i  (resp),
      .rdata_o (rdata),
      .seen_o  (seen),
      .full_o  (full)
   );

endmodule

// File: tb/tb_mem_line_client.sv
// Directed bench for mem_line_client: read, write, held and
// out-of-order responses, bad ptr and reset mid-transfer.
module tb_mem_line_client;

   logic         clk = 1'b0;
   logic         reset;
   logic         start, we;
   logic [63:0]  addr;
   logic [511:0] wdata;
   logic         idle, done, err;
   logic [511:0] rdata;
   logic         reqcyc, reqack;
   logic [63:0]  req;
   logic [12:0]  reqtag;
   logic         respcyc, respack;
   logic [63:0]  resp;
   logic [8:0]   ptr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0;
   int ord[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_line_client dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .idle    (idle),
      .done    (done),
      .rdata   (rdata),
      .err     (err),
      .reqcyc  (reqcyc),
      .reqack  (reqack),
      .req     (req),
      .reqtag  (reqtag),
      .respcyc (respcyc),
      .respack (respack),
      .resp    (resp),
      .ptr     (ptr)
   );

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] line_of(input logic [63:0] base);
      logic [511:0] l;
      for (int i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
      return l;
   endfunction

   task automatic begin_op(input logic w, input logic [63:0] a,
                           input logic [511:0] wd);
      @(negedge clk);
      start = 1'b1;
      we    = w;
      addr  = a;
      wdata = wd;
      t0    = cyc;
      #1 chk("idle before start", idle, 1'b1);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("reqcyc addr", reqcyc, 1'b1);
      chk("req addr", req, {a[63:6], 6'b0});
      chk("reqtag addr", reqtag, {w, 12'h000});
      chk("err cleared", err, 1'b0);
   endtask

   task automatic addr_phase();
      reqack = 1'b1;
      @(negedge clk);
      reqack = 1'b0;
      #1 chk("reqcyc rbeat", reqcyc, 1'b0);
   endtask

   task automatic send(input int p, input logic [63:0] d,
                       input logic exp_ack);
      respcyc = 1'b1;
      ptr     = 9'(p);
      resp    = d;
      #1 chk($sformatf("respack p%0d", p), respack, exp_ack);
      @(negedge clk);
      respcyc = 1'b0;
   endtask

   task automatic fin_check(input logic [63:0] base, input logic e);
      #1;
      chk("done pulse", done, 1'b1);
      chk("rdata line", rdata, line_of(base));
      chk("err at done", err, e);
      @(negedge clk);
      #1;
      chk("done single", done, 1'b0);
      chk("idle after", idle, 1'b1);
      chk("rdata held", rdata, line_of(base));
   endtask

   task automatic read_line(input logic [63:0] a, input logic [63:0] base,
                            input logic poke);
      begin_op(1'b0, a, '0);
      addr_phase();
      if (poke) begin
         start = 1'b1;
         we    = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #1 chk("busy start ignored", reqcyc, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         if (k == 7) chk("no early done", done, 1'b0);
         send(ord[k], base + 64'(ord[k]), 1'b1);
      end
      fin_check(base, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      reqack  = 1'b1;
      respcyc = 1'b1;
      resp    = '1;
      ptr     = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst idle", idle, 1'b1);
      chk("rst reqcyc", reqcyc, 1'b0);
      chk("rst respack", respack, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst req", req, '0);
      chk("rst reqtag", reqtag, '0);
      chk("rst rdata", rdata, '0);
      chk("rst err", err, 1'b0);
      reqack  = 1'b0;
      respcyc = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // response outside a read phase must not be acknowledged
      @(negedge clk);
      respcyc = 1'b1;
      ptr     = 9'd0;
      #1 chk("respack idle", respack, 1'b0);
      respcyc = 1'b0;

      // in-order read with a start poked while busy
      ord = '{0, 1, 2, 3, 4, 5, 6, 7};
      read_line(64'h1047, 64'h100, 1'b1);

      // write, zero-wait reqack
      begin_op(1'b1, 64'h2000, line_of(64'hA0));
      reqack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("wr beat%0d", i), req, 64'hA0 + 64'(i));
         chk("wr reqtag", reqtag, 13'h1000);
         chk("wr no done", done, 1'b0);
      end
      @(negedge clk);
      reqack = 1'b0;
      #1;
      chk("wr done", done, 1'b1);
      chk("wr latency", 32'(cyc - t0), 32'd10);
      chk("wr reqcyc fin", reqcyc, 1'b0);
      @(negedge clk);
      #1 chk("wr done single", done, 1'b0);

      // respcyc held three cycles on one ptr
      begin_op(1'b0, 64'h3000, '0);
      addr_phase();
      respcyc = 1'b1;
      ptr     = 9'd2;
      resp    = 64'h302;
      #1 chk("held ack1", respack, 1'b1);
      @(negedge clk);
      resp = 64'hBAD1;
      #1 chk("held ack2", respack, 1'b0);
      @(negedge clk);
      resp = 64'hBAD2;
      #1 chk("held ack3", respack, 1'b0);
      @(negedge clk);
      respcyc = 1'b0;
      ord = '{0, 1, 3, 4, 5, 6, 7, 0};
      for (int k = 0; k < 7; k++) send(ord[k], 64'h300 + 64'(ord[k]), 1'b1);
      fin_check(64'h300, 1'b0);

      // out-of-range ptr: acked, dropped, sticky err
      begin_op(1'b0, 64'h4000, '0);
      addr_phase();
      send(9, 64'hDEAD, 1'b1);
      #1 chk("err set", err, 1'b1);
      for (int k = 0; k < 8; k++) send(k, 64'h400 + 64'(k), 1'b1);
      fin_check(64'h400, 1'b1);

      // out-of-order beats; start also clears err
      ord = '{7, 0, 3, 1, 6, 2, 5, 4};
      read_line(64'h5000, 64'h200, 1'b0);

      // reset during write beat 4
      begin_op(1'b1, 64'h6000, line_of(64'hA0));
      reqack = 1'b1;
      repeat (5) @(negedge clk);
      #1 chk("pre-rst beat4", req, 64'hA4);
      #1 reset = 1'b0;
      #1;
      chk("mid rst reqcyc", reqcyc, 1'b0);
      chk("mid rst req", req, '0);
      chk("mid rst reqtag", reqtag, '0);
      chk("mid rst idle", idle, 1'b1);
      chk("mid rst done", done, 1'b0);
      chk("mid rst rdata", rdata, '0);
      chk("mid rst err", err, 1'b0);
      reqack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1 chk("no done in rst", done, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1 chk("no done after rst", done, 1'b0);
      ord = '{0, 1, 2, 3, 4, 5, 6, 7};
      read_line(64'h7011, 64'h600, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
